// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter with a polled status word on the IO page.
// Define UART_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise a single holding register is used.
module uart_tx_io #(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        io_sel,
    input  logic [29:0] wordaddr,
    input  logic [31:0] wdata,
    input  logic        wstrb,
    input  logic        rstrb,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned BIT_W = 3;
    localparam int unsigned BYTE_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [BYTE_W-1:0]   shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                ovf_q, ovf_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                wr_c, rd_c, pop_c, push_c, ovf_set_c;
    logic                full_c, empty_c, busy_c;
    logic [BYTE_W-1:0]   head_c;
    logic                unused_c;

    assign wr_c      = io_sel & wstrb & wordaddr[1];
    assign rd_c      = io_sel & rstrb & wordaddr[2];
    // A write while full still lands if the FSM frees a slot in the same cycle.
    assign push_c    = wr_c & (~full_c | pop_c);
    assign ovf_set_c = wr_c & full_c & ~pop_c;
    assign busy_c    = (state_q != ST_IDLE) | ~empty_c;
    assign unused_c  = ^{wordaddr[29:3], wordaddr[0], wdata[31:8]};

`ifdef UART_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [BYTE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_c);
        rd_ptr_d = rd_ptr_q + PW'(pop_c);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; pointer equality marks it empty.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata[BYTE_W-1:0];
        end
    end
`else
    logic [BYTE_W-1:0] hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic              unused_depth_c;

    assign empty_c        = ~hold_vld_q;
    assign full_c         = hold_vld_q;
    assign head_c         = hold_q;
    assign unused_depth_c = FIFO_DEPTH[0];

    always_comb begin
        hold_d     = push_c ? wdata[BYTE_W-1:0] : hold_q;
        hold_vld_d = push_c | (hold_vld_q & ~pop_c);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end
`endif

    // Frame sequencer: start, 8 data bits LSB first, stop; chains frames without idle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_c   = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!empty_c) begin
                    state_d = ST_START;
                    pop_c   = 1'b1;
                    shift_d = head_c;
                    baud_d  = '0;
                end
            end
            ST_START: begin
                if (baud_q == CNT_MAX) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == CNT_MAX) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[BYTE_W-1:1]};
                    if (bit_q == BIT_W'(7)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_q == CNT_MAX) begin
                    baud_d = '0;
                    if (!empty_c) begin
                        state_d = ST_START;
                        pop_c   = 1'b1;
                        shift_d = head_c;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level follows the state being entered so tx is a clean flop output.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Sticky overflow: a status read clears it unless an overflow lands in the same cycle.
    always_comb begin
        ovf_d   = ovf_q;
        rdata_d = rdata_q;
        if (rd_c) begin
            ovf_d   = 1'b0;
            rdata_d = {21'b0, ovf_q, busy_c, full_c, 8'b0};
        end
        if (ovf_set_c) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

    assign tx    = tx_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_uart_tx_io.sv
// Scoreboarded bench for uart_tx_io at DIV=8: a line decoder checks every frame against queued bytes.
module tb_uart_tx_io;

    localparam int unsigned DIV   = 8;
    localparam int unsigned FRAME = 10 * DIV;
`ifdef UART_FIFO_EN
    localparam int unsigned DEPTH = 4;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam logic [29:0] WA_DAT  = 30'h2;
    localparam logic [29:0] WA_CNTL = 30'h4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        io_sel = 1'b0;
    logic [29:0] wordaddr = '0;
    logic [31:0] wdata = '0;
    logic        wstrb = 1'b0;
    logic        rstrb = 1'b0;
    logic [31:0] rdata;
    logic        tx;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;

    logic [7:0]  sb_q[$];
    int unsigned start_log[$];

    uart_tx_io #(
        .CLK_FREQ  (8),
        .BAUD      (1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .io_sel  (io_sel),
        .wordaddr(wordaddr),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .rstrb   (rstrb),
        .rdata   (rdata),
        .tx      (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: samples mid-bit, pops the scoreboard at the stop bit.
    bit          rx_act = 1'b0;
    int unsigned rx_cnt = 0;
    int unsigned rx_k   = 0;
    logic [7:0]  rx_sh  = '0;
    logic [7:0]  rx_exp = '0;
    logic        tx_prev = 1'b1;

    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_act  = 1'b0;
            rx_cnt  = 0;
            tx_prev = 1'b1;
        end else begin
            if (!rx_act) begin
                if (tx_prev === 1'b1 && tx === 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                    start_log.push_back(cyc);
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % DIV == DIV / 2) begin
                    rx_k = rx_cnt / DIV;
                    if (rx_k == 0) begin
                        n_checks++;
                        if (tx !== 1'b0) begin
                            n_fail++;
                            $display("FAIL start_bit got=%b exp=0 cyc=%0d", tx, cyc);
                        end
                    end else if (rx_k <= 8) begin
                        rx_sh[rx_k-1] = tx;
                    end else begin
                        n_checks++;
                        if (tx !== 1'b1) begin
                            n_fail++;
                            $display("FAIL stop_bit got=%b exp=1 cyc=%0d", tx, cyc);
                        end
                        n_checks++;
                        if (sb_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_frame got=%02h exp=none cyc=%0d", rx_sh, cyc);
                        end else begin
                            rx_exp = sb_q.pop_front();
                            if (rx_sh !== rx_exp) begin
                                n_fail++;
                                $display("FAIL frame_byte got=%02h exp=%02h cyc=%0d", rx_sh, rx_exp, cyc);
                            end
                        end
                    end
                end
                if (rx_cnt == FRAME - 1) rx_act = 1'b0;
            end
            tx_prev = tx;
        end
    end

    // Bus helpers: entered and left at a falling edge; each spans exactly one rising edge.
    task automatic wr(input logic sel, input logic [29:0] wa, input logic [7:0] d);
        io_sel   = sel;
        wordaddr = wa;
        wdata    = {24'hC3C3C3, d};
        wstrb    = 1'b1;
        @(negedge clk);
        io_sel   = 1'b0;
        wordaddr = '0;
        wstrb    = 1'b0;
    endtask

    task automatic rd_status(output logic [31:0] v);
        io_sel   = 1'b1;
        wordaddr = WA_CNTL;
        rstrb    = 1'b1;
        @(negedge clk);
        io_sel   = 1'b0;
        wordaddr = '0;
        rstrb    = 1'b0;
        v = rdata;
    endtask

    task automatic wait_drain(output bit ok);
        int unsigned n = 0;
        while ((sb_q.size() != 0 || rx_act) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ok = (sb_q.size() == 0) && !rx_act;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got=%b exp=1", tx); end
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%08h exp=00000000", rdata); end
        rstn = 1'b1;
        @(negedge clk);
        rd_status(v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL reset_status got=%08h exp=00000000", v); end
    endtask

    task automatic test_single_byte;
        logic [7:0]  b = 8'hA5;
        logic [31:0] v, v_mid;
        logic        exp_bit;
        logic        got_bit;
        bit          cell_bad;
        v_mid = 'x;
        sb_q.push_back(b);
        wr(1'b1, WA_DAT, b);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL single_pre_start got=%b exp=1", tx); end
        cell_bad = 1'b0;
        got_bit  = 1'b1;
        for (int i = 0; i < int'(FRAME); i++) begin
            @(negedge clk);
            if (i < 8)       exp_bit = 1'b0;
            else if (i < 72) exp_bit = b[(i - 8) / 8];
            else             exp_bit = 1'b1;
            if (tx !== exp_bit) begin cell_bad = 1'b1; got_bit = tx; end
            if (i == 21) begin
                v_mid = rdata;
                io_sel = 1'b0; wordaddr = '0; rstrb = 1'b0;
            end
            if (i == 20) begin
                io_sel = 1'b1; wordaddr = WA_CNTL; rstrb = 1'b1;
            end
            if (i % 8 == 7) begin
                n_checks++;
                if (cell_bad) begin
                    n_fail++;
                    $display("FAIL single_cell%0d got=%b exp=%b", i / 8, got_bit, exp_bit);
                end
                cell_bad = 1'b0;
            end
        end
        n_checks++;
        if (v_mid !== 32'h200) begin n_fail++; $display("FAIL single_busy_mid got=%08h exp=00000200", v_mid); end
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL single_idle_tx got=%b exp=1", tx); end
        rd_status(v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL single_busy_after got=%08h exp=00000000", v); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] v, exp_v;
        int unsigned nb, s0, n;
        bit ok;
        nb = (DEPTH + 1 >= 4) ? 4 : DEPTH + 1;
        s0 = start_log.size();
        for (int k = 0; k < int'(nb); k++) begin
            sb_q.push_back(8'(k + 1));
            wr(1'b1, WA_DAT, 8'(k + 1));
        end
        rd_status(v);
        exp_v = (nb - 1 == DEPTH) ? 32'h300 : 32'h200;
        n_checks++;
        if (v !== exp_v) begin n_fail++; $display("FAIL b2b_status got=%08h exp=%08h", v, exp_v); end
        for (int k = int'(nb); k < 4; k++) begin
            n = 0;
            rd_status(v);
            while (v[8] === 1'b1 && n < 400) begin
                rd_status(v);
                n++;
            end
            n_checks++;
            if (v[8] !== 1'b0) begin n_fail++; $display("FAIL b2b_poll_full got=%b exp=0", v[8]); end
            sb_q.push_back(8'(k + 1));
            wr(1'b1, WA_DAT, 8'(k + 1));
        end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_drain got=pending%0d exp=0", sb_q.size()); end
        n_checks++;
        if (start_log.size() - s0 != 4) begin
            n_fail++;
            $display("FAIL b2b_frames got=%0d exp=4", start_log.size() - s0);
        end else begin
            for (int k = 1; k < 4; k++) begin
                n_checks++;
                if (start_log[s0 + k] - start_log[s0 + k - 1] != FRAME) begin
                    n_fail++;
                    $display("FAIL b2b_gap%0d got=%0d exp=%0d", k,
                             start_log[s0 + k] - start_log[s0 + k - 1], FRAME);
                end
            end
        end
        rd_status(v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL b2b_idle_status got=%08h exp=00000000", v); end
    endtask

    task automatic test_overflow;
        logic [31:0] v;
        bit ok;
        for (int k = 0; k <= int'(DEPTH); k++) begin
            sb_q.push_back(8'(8'h10 + k));
            wr(1'b1, WA_DAT, 8'(8'h10 + k));
        end
        wr(1'b1, WA_DAT, 8'h55);
        rd_status(v);
        n_checks++;
        if (v !== 32'h700) begin n_fail++; $display("FAIL ovf_status got=%08h exp=00000700", v); end
        rd_status(v);
        n_checks++;
        if (v !== 32'h300) begin n_fail++; $display("FAIL ovf_cleared got=%08h exp=00000300", v); end
        // Overflowing write and status read in one cycle: read sees old ovf, ovf stays set.
        io_sel = 1'b1; wordaddr = 30'h6; wdata = 32'h66; wstrb = 1'b1; rstrb = 1'b1;
        @(negedge clk);
        io_sel = 1'b0; wordaddr = '0; wstrb = 1'b0; rstrb = 1'b0;
        v = rdata;
        n_checks++;
        if (v !== 32'h300) begin n_fail++; $display("FAIL ovf_same_cycle_read got=%08h exp=00000300", v); end
        rd_status(v);
        n_checks++;
        if (v !== 32'h700) begin n_fail++; $display("FAIL ovf_same_cycle_sticky got=%08h exp=00000700", v); end
        rd_status(v);
        n_checks++;
        if (v !== 32'h300) begin n_fail++; $display("FAIL ovf_reclear got=%08h exp=00000300", v); end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ovf_drain got=pending%0d exp=0", sb_q.size()); end
        rd_status(v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL ovf_idle_status got=%08h exp=00000000", v); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] v;
        int unsigned s0;
        bit tx_bad;
        wr(1'b1, WA_DAT, 8'h00);
        wr(1'b1, WA_DAT, 8'h01);
        repeat (34) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx got=%b exp=1", tx); end
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata got=%08h exp=00000000", rdata); end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        s0 = start_log.size();
        tx_bad = 1'b0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_bad = 1'b1;
        end
        n_checks++;
        if (tx_bad || start_log.size() != s0) begin
            n_fail++;
            $display("FAIL rst_mid_no_frames got=frames%0d exp=0", start_log.size() - s0);
        end
        rd_status(v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL rst_mid_status got=%08h exp=00000000", v); end
    endtask

    task automatic test_decode;
        logic [31:0] v;
        int unsigned s0;
        bit tx_bad;
        s0 = start_log.size();
        wr(1'b0, WA_DAT, 8'hFF);
        wr(1'b1, 30'h1, 8'hFF);
        tx_bad = 1'b0;
        repeat (3 * DIV) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_bad = 1'b1;
        end
        n_checks++;
        if (tx_bad || start_log.size() != s0) begin
            n_fail++;
            $display("FAIL decode_tx got=frames%0d exp=0", start_log.size() - s0);
        end
        rd_status(v);
        n_checks++;
        if (v !== 32'h0) begin n_fail++; $display("FAIL decode_status got=%08h exp=00000000", v); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_decode();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
